// File: rtl/data_mem_sized_if.sv
// Request/response bus of the sized data memory: one access per cycle,
// load results and error flags come back one cycle after acceptance.
interface data_mem_sized_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        ready;
   logic        busy;
   logic        rvalid;
   logic [31:0] read_data;
   logic        err;

   modport master (
      output req, we, size, sign_ext, addr, write_data,
      input  ready, busy, rvalid, read_data, err
   );

   modport slave (
      input  req, we, size, sign_ext, addr, write_data,
      output ready, busy, rvalid, read_data, err
   );
endinterface

// File: rtl/data_mem_sized.sv
// Single-port word-organised data memory with byte/halfword/word access,
// load sign extension and a post-reset sequential clear of every word.
module data_mem_sized #(
   parameter int unsigned DATA_MEM_SIZE = 64,
   parameter logic [31:0] INIT_VAL      = 32'h0,
   localparam int unsigned IDX_W        = $clog2(DATA_MEM_SIZE)
) (
   input  logic             clk,
   input  logic             rst,
   data_mem_sized_if.slave  bus
);

   typedef enum logic [0:0] {CLEAR, IDLE} state_e;

   state_e           state_q;
   logic [IDX_W-1:0] clr_ptr_q;
   logic             ready_q;
   logic             busy_q;
   logic             rvalid_q;
   logic             err_q;
   logic [31:0]      read_data_q;

   logic [31:0]      mem [DATA_MEM_SIZE];

   logic [29:0]      word_addr;
   logic [IDX_W-1:0] idx;
   logic             out_of_range;
   logic             misaligned;
   logic             illegal;
   logic             accept;
   logic             store_en;
   logic             clear_en;

   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [31:0]      wr_data;
   logic [3:0]       wr_be;

   logic [31:0]      rd_word;
   logic [7:0]       rd_byte;
   logic [15:0]      rd_half;
   logic [31:0]      load_val;

   // Address decode and legality of the presented request
   always_comb begin
      word_addr    = bus.addr[31:2];
      idx          = bus.addr[IDX_W+1:2];
      out_of_range = (word_addr >= 30'(DATA_MEM_SIZE));
      misaligned   = ((bus.size == 2'b01) && bus.addr[0])
                  || ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00))
                  || (bus.size == 2'b11);
      illegal      = out_of_range || misaligned;
      accept       = bus.req && (state_q == IDLE) && !rst;
      store_en     = accept && bus.we && !illegal;
      clear_en     = (state_q == CLEAR) && !rst;
   end

   // Single write port shared by the clear sequence and stores
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = idx;
      wr_data = '0;
      wr_be   = 4'b0000;
      if (clear_en) begin
         wr_en   = 1'b1;
         wr_idx  = clr_ptr_q;
         wr_data = INIT_VAL;
         wr_be   = 4'b1111;
      end else if (store_en) begin
         wr_en = 1'b1;
         unique case (bus.size)
            2'b00: begin
               wr_data = {4{bus.write_data[7:0]}};
               wr_be   = 4'(4'b0001 << bus.addr[1:0]);
            end
            2'b01: begin
               wr_data = {2{bus.write_data[15:0]}};
               wr_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
               wr_data = bus.write_data;
               wr_be   = 4'b1111;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // Lane selection and extension of the addressed word
   always_comb begin
      rd_word = mem[idx];
      unique case (bus.addr[1:0])
         2'b00:   rd_byte = rd_word[7:0];
         2'b01:   rd_byte = rd_word[15:8];
         2'b10:   rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
      rd_half  = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];
      load_val = rd_word;
      unique case (bus.size)
         2'b00:   load_val = bus.sign_ext ? {{24{rd_byte[7]}}, rd_byte}
                                          : {24'h0, rd_byte};
         2'b01:   load_val = bus.sign_ext ? {{16{rd_half[15]}}, rd_half}
                                          : {16'h0, rd_half};
         default: load_val = rd_word;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLEAR;
         clr_ptr_q   <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b1;
         rvalid_q    <= 1'b0;
         err_q       <= 1'b0;
         read_data_q <= '0;
      end else begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         unique case (state_q)
            CLEAR: begin
               clr_ptr_q <= clr_ptr_q + IDX_W'(1);
               if (clr_ptr_q == IDX_W'(DATA_MEM_SIZE - 1)) begin
                  state_q   <= IDLE;
                  clr_ptr_q <= '0;
                  ready_q   <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            IDLE: begin
               if (accept) begin
                  err_q    <= illegal;
                  rvalid_q <= !bus.we;
                  if (!bus.we) read_data_q <= illegal ? 32'h0 : load_val;
               end
            end
            default: state_q <= CLEAR;
         endcase
      end
   end

   assign bus.ready     = ready_q;
   assign bus.busy      = busy_q;
   assign bus.rvalid    = rvalid_q;
   assign bus.err       = err_q;
   assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed bench for data_mem_sized: clear timing, sized stores/loads,
// legality errors and reset restart with hand-computed expectations.
module tb_data_mem_sized;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   data_mem_sized_if bus ();

   data_mem_sized #(.DATA_MEM_SIZE(64), .INIT_VAL(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One accepted access; outputs sampled 1 time unit after the accepting edge
   task automatic access(input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic rv, output logic er, output logic [31:0] rd);
      bus.req        = 1'b1;
      bus.we         = we;
      bus.size       = sz;
      bus.sign_ext   = sx;
      bus.addr       = a;
      bus.write_data = wd;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      rv = bus.rvalid;
      er = bus.err;
      rd = bus.read_data;
   endtask

   // Pulse reset, then count edges until ready rises (bounded)
   task automatic pulse_reset(output int cycles, output logic busy_gap);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      cycles   = 0;
      busy_gap = 1'b0;
      while (!bus.ready && cycles < 200) begin
         if (bus.busy !== 1'b1) busy_gap = 1'b1;
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      int cyc;
      logic gap, rv, er;
      logic [31:0] rd;
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (bus.ready !== 1'b0 || bus.busy !== 1'b1 || bus.rvalid !== 1'b0 ||
          bus.err !== 1'b0 || bus.read_data !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs got rdy=%b busy=%b rv=%b err=%b rd=%h exp 0 1 0 0 0",
                  bus.ready, bus.busy, bus.rvalid, bus.err, bus.read_data);
      end
      pulse_reset(cyc, gap);
      total++;
      if (cyc !== 64 || gap !== 1'b0) begin
         bad++;
         $display("FAIL reset_clear_len got cycles=%0d busy_gap=%b exp 64 0", cyc, gap);
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_busy_drop got=%b exp=0", bus.busy);
      end
      access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rv, er, rd);
      total++;
      if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
         bad++;
         $display("FAIL reset_load0 got rv=%b err=%b rd=%h exp 1 0 00000000", rv, er, rd);
      end
      access(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, rv, er, rd);
      total++;
      if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
         bad++;
         $display("FAIL reset_loadFC got rv=%b err=%b rd=%h exp 1 0 00000000", rv, er, rd);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.rvalid !== 1'b0) begin
         bad++;
         $display("FAIL rvalid_pulse got=%b exp=0", bus.rvalid);
      end
   endtask

   task automatic test_back_to_back();
      logic rv, er;
      logic [31:0] rd;
      access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rv, er, rd);
      total++;
      if (rv !== 1'b0 || er !== 1'b0) begin
         bad++;
         $display("FAIL store_no_rvalid got rv=%b err=%b exp 0 0", rv, er);
      end
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rv, er, rd);
      total++;
      if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL b2b_load got rv=%b err=%b rd=%h exp 1 0 deadbeef", rv, er, rd);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.rvalid !== 1'b0 || bus.read_data !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL rdata_hold got rv=%b rd=%h exp 0 deadbeef", bus.rvalid, bus.read_data);
      end
   endtask

   task automatic test_byte();
      logic rv, er;
      logic [31:0] rd;
      access(1'b1, 2'b00, 1'b0, 32'h21, 32'hAAAAAA80, rv, er, rd);
      access(1'b1, 2'b00, 1'b0, 32'h22, 32'h5555557F, rv, er, rd);
      access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rv, er, rd);
      total++;
      if (rv !== 1'b1 || rd !== 32'h007F8000) begin
         bad++;
         $display("FAIL byte_word_view got rv=%b rd=%h exp 1 007f8000", rv, rd);
      end
      access(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rv, er, rd);
      total++;
      if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
         bad++;
         $display("FAIL byte_load_sext got rd=%h err=%b exp ffffff80 0", rd, er);
      end
      access(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rv, er, rd);
      total++;
      if (rd !== 32'h00000080) begin
         bad++;
         $display("FAIL byte_load_zext got=%h exp=00000080", rd);
      end
      access(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, rv, er, rd);
      total++;
      if (rd !== 32'h0000007F) begin
         bad++;
         $display("FAIL byte_load_pos_sext got=%h exp=0000007f", rd);
      end
   endtask

   task automatic test_halfword_misaligned();
      logic rv, er;
      logic [31:0] rd;
      access(1'b1, 2'b01, 1'b0, 32'h31, 32'h00001234, rv, er, rd);
      total++;
      if (er !== 1'b1 || rv !== 1'b0) begin
         bad++;
         $display("FAIL half_misal_store got err=%b rv=%b exp 1 0", er, rv);
      end
      access(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000ABCD, rv, er, rd);
      total++;
      if (er !== 1'b0) begin
         bad++;
         $display("FAIL half_store_err got=%b exp=0", er);
      end
      access(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, rv, er, rd);
      total++;
      if (rv !== 1'b1 || rd !== 32'hFFFFABCD) begin
         bad++;
         $display("FAIL half_load_sext got rv=%b rd=%h exp 1 ffffabcd", rv, rd);
      end
      access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rv, er, rd);
      total++;
      if (rd !== 32'hABCD0000 || er !== 1'b0) begin
         bad++;
         $display("FAIL half_word_view got rd=%h err=%b exp abcd0000 0", rd, er);
      end
      access(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, rv, er, rd);
      total++;
      if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
         bad++;
         $display("FAIL word_misal_load got rv=%b err=%b rd=%h exp 1 1 0", rv, er, rd);
      end
      access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rv, er, rd);
      total++;
      if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
         bad++;
         $display("FAIL reserved_size got rv=%b err=%b rd=%h exp 1 1 0", rv, er, rd);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.err !== 1'b0) begin
         bad++;
         $display("FAIL err_pulse got=%b exp=0", bus.err);
      end
   endtask

   task automatic test_range();
      logic rv, er;
      logic [31:0] rd;
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rv, er, rd);
      access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rv, er, rd);
      total++;
      if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
         bad++;
         $display("FAIL oor_load got rv=%b err=%b rd=%h exp 1 1 0", rv, er, rd);
      end
      access(1'b1, 2'b10, 1'b0, 32'h100, 32'h11111111, rv, er, rd);
      total++;
      if (er !== 1'b1 || rv !== 1'b0) begin
         bad++;
         $display("FAIL oor_store got err=%b rv=%b exp 1 0", er, rv);
      end
      access(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h22222222, rv, er, rd);
      total++;
      if (er !== 1'b1) begin
         bad++;
         $display("FAIL oor_high_store got err=%b exp 1", er);
      end
      access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rv, er, rd);
      total++;
      if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
         bad++;
         $display("FAIL oor_no_wrap0 got rv=%b err=%b rd=%h exp 1 0 0", rv, er, rd);
      end
      access(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, rv, er, rd);
      total++;
      if (rd !== 32'h0 || er !== 1'b0) begin
         bad++;
         $display("FAIL oor_no_wrapFC got rd=%h err=%b exp 0 0", rd, er);
      end
   endtask

   task automatic test_clear_restart();
      int cyc;
      logic gap, rv, er, seen_rv;
      logic [31:0] rd;
      access(1'b1, 2'b10, 1'b0, 32'h8, 32'h00000055, rv, er, rd);
      access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rv, er, rd);
      total++;
      if (rd !== 32'h00000055) begin
         bad++;
         $display("FAIL restart_pre got=%h exp=00000055", rd);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      seen_rv = 1'b0;
      bus.req = 1'b1;
      bus.we  = 1'b0;
      bus.size = 2'b10;
      bus.addr = 32'h8;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.rvalid !== 1'b0 || bus.err !== 1'b0 || bus.ready !== 1'b0) seen_rv = 1'b1;
      end
      bus.req = 1'b0;
      total++;
      if (seen_rv !== 1'b0) begin
         bad++;
         $display("FAIL clear_ignores_req got activity=%b exp=0", seen_rv);
      end
      pulse_reset(cyc, gap);
      total++;
      if (cyc !== 64 || gap !== 1'b0) begin
         bad++;
         $display("FAIL restart_clear_len got cycles=%0d busy_gap=%b exp 64 0", cyc, gap);
      end
      access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rv, er, rd);
      total++;
      if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
         bad++;
         $display("FAIL restart_load8 got rv=%b err=%b rd=%h exp 1 0 0", rv, er, rd);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      total          = 0;
      bad            = 0;
      rst            = 1'b0;
      bus.req        = 1'b0;
      bus.we         = 1'b0;
      bus.size       = 2'b10;
      bus.sign_ext   = 1'b0;
      bus.addr       = 32'h0;
      bus.write_data = 32'h0;
      @(negedge clk);
      test_reset();
      test_back_to_back();
      test_byte();
      test_halfword_misaligned();
      test_range();
      test_clear_restart();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
